// File: rtl/drum_node_init_loader.sv
// drum_node_init_loader
// Copies the initial-displacement table into the u(n) and u(n-1) node memories.
// The loader walks node indices 0..NUM_NODES-1. It drives the address of a combinational
// init-value LUT. Each returned value is arithmetically right-shifted by the captured
// attenuation and then written to both memories over the shared wr_* bus. The node-update
// solver is held off while the load runs, and done pulses for one cycle at the end.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   synchronous active-low reset
//   start        in   load request, only honoured while idle
//   amp_shift    in   attenuation shift amount, captured when a load starts
//   lut_addr     out  init-value LUT address
//   lut_data     in   init-value LUT data, valid in the same cycle as lut_addr
//   wr_en        out  write strobe to both node memories
//   wr_addr      out  node index being written
//   wr_data      out  attenuated value written to both memories
//   solver_hold  out  high while loading; the solver must not step
//   busy         out  load in progress
//   done         out  one-cycle pulse after the final write
module drum_node_init_loader #(
    parameter int unsigned NUM_NODES  = 30,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        amp_shift,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              solver_hold,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_NODES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic [2:0]        shift_q, shift_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    // Set by reset. It stands in for start on the first edge after reset is released.
    logic              auto_q, auto_d;
    logic              start_eff;

    always_comb begin
        state_d    = state_q;
        lut_addr_d = lut_addr_q;
        shift_d    = shift_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        auto_d     = 1'b0;
        start_eff  = start | auto_q;

        unique case (state_q)
            StIdle: begin
                done_d     = 1'b0;
                lut_addr_d = '0;
                if (start_eff) begin
                    state_d = StLoad;
                    shift_d = amp_shift;
                    busy_d  = 1'b1;
                end
            end
            StLoad: begin
                wr_en_d   = 1'b1;
                wr_addr_d = lut_addr_q;
                wr_data_d = $signed(lut_data) >>> shift_q;
                if (lut_addr_q == LastAddr) begin
                    // Hold the address at the last node so it never wraps.
                    state_d = StDone;
                end else begin
                    lut_addr_d = lut_addr_q + 1'b1;
                end
            end
            StDone: begin
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            lut_addr_q <= '0;
            shift_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            auto_q     <= AUTO_START;
        end else begin
            state_q    <= state_d;
            lut_addr_q <= lut_addr_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            auto_q     <= auto_d;
        end
    end

    assign lut_addr    = lut_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign solver_hold = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_drum_node_init_loader.sv
module tb_drum_node_init_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  amp_shift = 3'd0;
    logic [4:0]  lut_addr;
    logic [31:0] lut_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        solver_hold;
    logic        busy;
    logic        done;
    logic        stub_mode = 1'b0;

    int errors = 0;
    int checks = 0;

    // Monitor state. Only the monitor writes these; tests read them and compare against
    // snapshots they take themselves.
    logic [4:0]  wa_log[$];
    logic [31:0] wd_log[$];
    int          done_cnt = 0;
    int          hold_bad = 0;

    always #5 clk = ~clk;

    drum_node_init_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .amp_shift  (amp_shift),
        .lut_addr   (lut_addr),
        .lut_data   (lut_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .solver_hold(solver_hold),
        .busy       (busy),
        .done       (done)
    );

    // Triangular pluck: zero at both ends, 0x8000 at nodes 14 and 15.
    function automatic logic [31:0] lut_fn(input logic [4:0] a);
        int n;
        int v;
        n = int'(a);
        if (n <= 14) v = (32768 * n) / 14;
        else if (n <= 29) v = (32768 * (29 - n)) / 14;
        else v = 0;
        return 32'(v);
    endfunction

    function automatic logic [31:0] exp_val(input int idx, input int sh);
        logic signed [31:0] s;
        s = lut_fn(5'(idx));
        return s >>> sh;
    endfunction

    always_comb lut_data = stub_mode ? 32'hFFFF8000 : lut_fn(lut_addr);

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
        end
        if (done === 1'b1) done_cnt++;
        if ((wr_en === 1'b1 && solver_hold !== 1'b1) || (done === 1'b1 && solver_hold !== 1'b0))
            hold_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin
                cycles = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b1;
        amp_shift = 3'd0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || solver_hold !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got busy=%b hold=%b expected 0/0", busy, solver_hold);
        end
        checks++;
        if (wr_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got wr_en=%b done=%b expected 0/0", wr_en, done);
        end
        checks++;
        if (lut_addr !== 5'd0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: got lut_addr=%0d wr_addr=%0d wr_data=%0h expected 0",
                     lut_addr, wr_addr, wr_data);
        end
        start = 1'b0;
    endtask

    task automatic test_auto_start();
        int base;
        int dbase;
        int c;
        int bad;
        base = wa_log.size();
        dbase = done_cnt;
        reset_n = 1'b1;
        wait_done(40, c);
        checks++;
        if (c !== 32) begin
            errors++;
            $display("FAIL auto_done_time: got %0d cycles expected 32", c);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL auto_done_pulse: got done=%b expected 0", done);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL auto_done_count: got %0d expected 1", done_cnt - dbase);
        end
        checks++;
        if (wa_log.size() - base !== 30) begin
            errors++;
            $display("FAIL auto_write_count: got %0d expected 30", wa_log.size() - base);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) if (wa_log[base + k] !== 5'(k)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL auto_addr_order: got %0d bad addresses expected 0", bad);
        end
        checks++;
        if (wd_log[base + 0] !== 32'h0 || wd_log[base + 7] !== 32'h4000 ||
            wd_log[base + 14] !== 32'h8000 || wd_log[base + 15] !== 32'h8000 ||
            wd_log[base + 29] !== 32'h0) begin
            errors++;
            $display("FAIL auto_data_points: got %0h %0h %0h %0h %0h expected 0 4000 8000 8000 0",
                     wd_log[base + 0], wd_log[base + 7], wd_log[base + 14],
                     wd_log[base + 15], wd_log[base + 29]);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) if (wd_log[base + k] !== exp_val(k, 0)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL auto_data_all: got %0d bad values expected 0", bad);
        end
    endtask

    task automatic test_shift();
        int base;
        int c;
        base = wa_log.size();
        amp_shift = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || solver_hold !== 1'b1) begin
            errors++;
            $display("FAIL shift_hold_on: got busy=%b hold=%b expected 1/1", busy, solver_hold);
        end
        wait_done(40, c);
        checks++;
        if (c !== 31) begin
            errors++;
            $display("FAIL shift_done_time: got %0d expected 31", c);
        end
        checks++;
        if (busy !== 1'b0 || solver_hold !== 1'b0) begin
            errors++;
            $display("FAIL shift_hold_off: got busy=%b hold=%b expected 0/0", busy, solver_hold);
        end
        checks++;
        if (wd_log[base + 14] !== 32'h2000 || wd_log[base + 1] !== 32'h249 ||
            wd_log[base + 3] !== 32'h6DB) begin
            errors++;
            $display("FAIL shift_data: got %0h %0h %0h expected 2000 249 6db",
                     wd_log[base + 14], wd_log[base + 1], wd_log[base + 3]);
        end
        repeat (2) tick();
    endtask

    task automatic test_ignore_start();
        int base;
        int dbase;
        int bad;
        base = wa_log.size();
        dbase = done_cnt;
        amp_shift = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 5) begin
                start = 1'b1;
                amp_shift = 3'd3;
            end else if (i == 6) begin
                start = 1'b0;
            end
        end
        checks++;
        if (wa_log.size() - base !== 30) begin
            errors++;
            $display("FAIL ignore_write_count: got %0d expected 30", wa_log.size() - base);
        end
        checks++;
        if (done_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - dbase);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) if (wd_log[base + k] !== exp_val(k, 1)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ignore_shift_held: got %0d bad values expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        int dbase;
        int c;
        int bad;
        logic hit;
        dbase = done_cnt;
        amp_shift = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_en === 1'b1 && wr_addr === 5'd10) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reach_write10: got %b expected 1", hit);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got wr_en=%b busy=%b done=%b expected 0/0/0",
                     wr_en, busy, done);
        end
        tick();
        checks++;
        if (done_cnt !== dbase) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt - dbase);
        end
        base = wa_log.size();
        reset_n = 1'b1;
        wait_done(40, c);
        checks++;
        if (c !== 32) begin
            errors++;
            $display("FAIL midrst_reload_time: got %0d expected 32", c);
        end
        repeat (2) tick();
        bad = 0;
        for (int k = 0; k < 30; k++) if (wa_log[base + k] !== 5'(k)) bad++;
        checks++;
        if (wa_log.size() - base !== 30 || bad !== 0) begin
            errors++;
            $display("FAIL midrst_reload_seq: got %0d writes %0d bad expected 30 0",
                     wa_log.size() - base, bad);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int bad_wr;
        int bad_done;
        int bad_addr;
        int p;
        int c;
        base = wa_log.size();
        amp_shift = 3'd0;
        start = 1'b1;
        bad_wr = 0;
        bad_done = 0;
        // Period 32: load-start cycle, 30 writes, done cycle (loader already idle).
        for (int t = 1; t <= 96; t++) begin
            tick();
            p = (t - 1) % 32;
            if (wr_en !== ((p >= 1 && p <= 30) ? 1'b1 : 1'b0)) bad_wr++;
            if (done !== ((p == 31) ? 1'b1 : 1'b0)) bad_done++;
        end
        start = 1'b0;
        wait_done(40, c);
        repeat (3) tick();
        checks++;
        if (bad_wr !== 0) begin
            errors++;
            $display("FAIL b2b_wr_en_pattern: got %0d bad cycles expected 0", bad_wr);
        end
        checks++;
        if (bad_done !== 0) begin
            errors++;
            $display("FAIL b2b_done_pattern: got %0d bad cycles expected 0", bad_done);
        end
        bad_addr = 0;
        for (int k = 0; k < 90; k++) if (wa_log[base + k] !== 5'(k % 30)) bad_addr++;
        checks++;
        if (bad_addr !== 0) begin
            errors++;
            $display("FAIL b2b_addr_order: got %0d bad addresses expected 0", bad_addr);
        end
    endtask

    task automatic test_sign_ext();
        int base;
        int c;
        int bad;
        base = wa_log.size();
        stub_mode = 1'b1;
        amp_shift = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, c);
        checks++;
        if (wd_log[base] !== 32'hFFFFC000) begin
            errors++;
            $display("FAIL signext_first: got %0h expected ffffc000", wd_log[base]);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) if (wd_log[base + k] !== 32'hFFFFC000) bad++;
        checks++;
        if (wa_log.size() - base !== 30 || bad !== 0) begin
            errors++;
            $display("FAIL signext_all: got %0d writes %0d bad expected 30 0",
                     wa_log.size() - base, bad);
        end
        stub_mode = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_shift();
        test_ignore_start();
        test_reset_mid_load();
        test_back_to_back();
        test_sign_ext();
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL hold_vs_writes: got %0d bad cycles expected 0", hold_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
